// File: rtl/wb_pkg.sv
// Shared writeback definitions: port widths, destination-mux select encodings
// and the hard-wired zero register.
package wb_pkg;

    localparam int ADDR_W = 5;
    localparam int DATA_W = 32;

    localparam logic SEL_RD = 1'b0;
    localparam logic SEL_RT = 1'b1;

    localparam logic [ADDR_W-1:0] REG_ZERO = '0;

    typedef enum logic {
        PRI_A = 1'b0,
        PRI_B = 1'b1
    } pri_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin grant; the pointer moves to the loser on every accept.
module rr_arb2
    import wb_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic a_valid,
    input  logic b_valid,
    input  logic en,
    output logic grant_b,
    output logic a_ready,
    output logic b_ready
);

    pri_t pri;
    logic grant_a;

    always_comb begin
        grant_b = b_valid && (!a_valid || (pri == PRI_B));
        grant_a = a_valid && !grant_b;
        a_ready = grant_a && en && !rst;
        b_ready = grant_b && en && !rst;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pri <= PRI_A;
        end else if (a_ready) begin
            pri <= PRI_B;
        end else if (b_ready) begin
            pri <= PRI_A;
        end
    end

endmodule

// File: rtl/wb_port_arbiter.sv
// Register-file write port shared by the ALU (A/rd) and load/multi-cycle (B/rt)
// results, with a one-entry output stage and a saturating contention counter.
module wb_port_arbiter #(
    parameter int ADDR_W = wb_pkg::ADDR_W,
    parameter int DATA_W = wb_pkg::DATA_W,
    parameter int CNT_W  = 8
) (
    input  logic              inClk,
    input  logic              inReset,
    input  logic              inAValid,
    input  logic [ADDR_W-1:0] inAAddr,
    input  logic [DATA_W-1:0] inAData,
    output logic              outAReady,
    input  logic              inBValid,
    input  logic [ADDR_W-1:0] inBAddr,
    input  logic [DATA_W-1:0] inBData,
    output logic              outBReady,
    output logic              outWValid,
    input  logic              inWReady,
    output logic              outWe,
    output logic [ADDR_W-1:0] outWAddr,
    output logic [DATA_W-1:0] outWData,
    output logic              outSel,
    output logic [CNT_W-1:0]  outConflicts
);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    logic              en;
    logic              grant_b;
    logic              accept;
    logic              vld_p1;
    logic [ADDR_W-1:0] addr_p1;
    logic [DATA_W-1:0] data_p1;
    logic              sel_p1;
    logic [CNT_W-1:0]  conflicts;

    assign en     = !vld_p1 || inWReady;
    assign accept = outAReady || outBReady;

    rr_arb2 u_arb (
        .clk     (inClk),
        .rst     (inReset),
        .a_valid (inAValid),
        .b_valid (inBValid),
        .en      (en),
        .grant_b (grant_b),
        .a_ready (outAReady),
        .b_ready (outBReady)
    );

    // Stage p1: registered writeback beat toward the register file
    always_ff @(posedge inClk) begin
        if (inReset) begin
            vld_p1  <= 1'b0;
            addr_p1 <= '0;
            data_p1 <= '0;
            sel_p1  <= wb_pkg::SEL_RD;
        end else if (accept) begin
            vld_p1  <= 1'b1;
            addr_p1 <= grant_b ? inBAddr : inAAddr;
            data_p1 <= grant_b ? inBData : inAData;
            sel_p1  <= grant_b ? wb_pkg::SEL_RT : wb_pkg::SEL_RD;
        end else if (inWReady) begin
            vld_p1  <= 1'b0;
        end
    end

    // Counts raw contention, regardless of whether the stage could accept.
    always_ff @(posedge inClk) begin
        if (inReset) begin
            conflicts <= '0;
        end else if (inAValid && inBValid) begin
            conflicts <= sat_inc(conflicts);
        end
    end

    assign outWValid    = vld_p1;
    assign outWAddr     = addr_p1;
    assign outWData     = data_p1;
    assign outSel       = sel_p1;
    assign outWe        = vld_p1 && (addr_p1 != ADDR_W'(wb_pkg::REG_ZERO));
    assign outConflicts = conflicts;

endmodule
